// File: rtl/dcdc_pwm_gen_pkg.sv
// Shared types and constants for the DC-DC PWM generator.
// Optional fault latch is built when DCDC_PWM_FAULT_EN is defined.
package dcdc_pkg;
  typedef logic signed [31:0] q16_16_t;

  localparam q16_16_t Q16_ONE  = 32'sh0001_0000;
  localparam q16_16_t Q16_HALF = 32'sh0000_8000;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_HI_ON,
    ST_FALL,
    ST_LO_ON,
    ST_RISE
  } dt_state_e;
endpackage

// File: rtl/dcdc_pwm_gen_deadtime.sv
// Complementary gate driver with dead-time; glitch-short raw pulses are swallowed.
// With DCDC_PWM_FAULT_EN a latched fault parks the FSM in OFF until cleared.
module dcdc_deadtime
  import dcdc_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEADTIME = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
`ifdef DCDC_PWM_FAULT_EN
  input  logic i_fault,
  input  logic i_fault_clr,
  output logic o_fault_latched,
`endif
  output logic o_pwm_hi,
  output logic o_pwm_lo
);
  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEADTIME);

  dt_state_e        state_q, state_d;
  logic [CNT_W-1:0] dt_q, dt_d;
  logic             hi_q, lo_q;
  logic             dt_done;

  // Leave the DT state on the cycle the counter steps to 0, so gates stay off DEADTIME cycles.
  assign dt_done = (dt_q <= CNT_W'(1));

`ifdef DCDC_PWM_FAULT_EN
  logic flt_q, flt_d, force_off;
  assign force_off       = i_fault | flt_q;
  assign flt_d           = i_fault | (flt_q & ~i_fault_clr);
  assign o_fault_latched = flt_q;
`endif

  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    case (state_q)
      ST_OFF: begin
        state_d = i_raw ? ST_RISE : ST_FALL;
        dt_d    = DT_LOAD;
      end
      ST_LO_ON: if (i_raw) begin
        state_d = ST_RISE;
        dt_d    = DT_LOAD;
      end
      ST_HI_ON: if (!i_raw) begin
        state_d = ST_FALL;
        dt_d    = DT_LOAD;
      end
      ST_RISE: begin
        if (!i_raw) begin
          state_d = ST_FALL;
          dt_d    = DT_LOAD;
        end else if (dt_done) begin
          state_d = ST_HI_ON;
          dt_d    = '0;
        end else begin
          dt_d    = dt_q - CNT_W'(1);
        end
      end
      ST_FALL: begin
        if (i_raw) begin
          state_d = ST_RISE;
          dt_d    = DT_LOAD;
        end else if (dt_done) begin
          state_d = ST_LO_ON;
          dt_d    = '0;
        end else begin
          dt_d    = dt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        dt_d    = '0;
      end
    endcase
`ifdef DCDC_PWM_FAULT_EN
    if (force_off) begin
      state_d = ST_OFF;
      dt_d    = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_OFF;
      dt_q    <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
`ifdef DCDC_PWM_FAULT_EN
      flt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      hi_q    <= (state_d == ST_HI_ON);
      lo_q    <= (state_d == ST_LO_ON);
`ifdef DCDC_PWM_FAULT_EN
      flt_q   <= flt_d;
`endif
    end
  end

  assign o_pwm_hi = hi_q;
  assign o_pwm_lo = lo_q;
endmodule

// File: rtl/dcdc_pwm_gen.sv
// PWM generator: clamps Q16.16 duty, double-buffers the compare, drives gates via dcdc_deadtime.
// Define DCDC_PWM_FAULT_EN to add the fault latch ports.
module dcdc_pwm_gen
  import dcdc_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter int          PERIOD   = 1000,
  parameter int          DEADTIME = 10,
  parameter logic [31:0] RST_DUTY = 32'h0000_8000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  q16_16_t        i_DC_control,
  input  logic           i_DV,
`ifdef DCDC_PWM_FAULT_EN
  input  logic           i_fault,
  input  logic           i_fault_clr,
  output logic           o_fault_latched,
`endif
  output logic           o_pwm_hi,
  output logic           o_pwm_lo,
  output logic           o_period_start,
  output logic           o_duty_applied,
  output logic [CNT_W:0] o_cmp_active
);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W:0]   RST_CMP  = (CNT_W+1)'((64'(RST_DUTY) * 64'(PERIOD)) >> 16);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [16:0]       clamp_d, s1_q;
  logic              s1_vld_q;
  logic [CNT_W+16:0] prod;
  logic [CNT_W:0]    pend_q, cmp_q;
  logic              pend_vld_q;
  logic              ps_q, da_q;
  logic              wrap, xfer, raw;

  assign wrap  = (cnt_q == LAST);
  assign cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  // Transfer only uses a pending value that was already registered before the wrap edge.
  assign xfer  = wrap & pend_vld_q;

  always_comb begin
    clamp_d = i_DC_control[16:0];
    if (i_DC_control[31])            clamp_d = '0;
    else if (i_DC_control > Q16_ONE) clamp_d = Q16_ONE[16:0];
  end

  assign prod = (CNT_W+17)'(s1_q) * (CNT_W+17)'(PERIOD_C);
  assign raw  = ({1'b0, cnt_q} < cmp_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      s1_q       <= '0;
      s1_vld_q   <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cmp_q      <= RST_CMP;
      ps_q       <= 1'b0;
      da_q       <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ps_q     <= wrap;
      da_q     <= xfer;
      s1_vld_q <= i_DV;
      if (i_DV) s1_q <= clamp_d;
      if (xfer) cmp_q <= pend_q;
      if (s1_vld_q) begin
        pend_q     <= (CNT_W+1)'(prod >> 16);
        pend_vld_q <= 1'b1;
      end else if (xfer) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  dcdc_deadtime #(
    .CNT_W    (CNT_W),
    .DEADTIME (DEADTIME)
  ) u_dt (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_raw           (raw),
`ifdef DCDC_PWM_FAULT_EN
    .i_fault         (i_fault),
    .i_fault_clr     (i_fault_clr),
    .o_fault_latched (o_fault_latched),
`endif
    .o_pwm_hi        (o_pwm_hi),
    .o_pwm_lo        (o_pwm_lo)
  );

  assign o_period_start = ps_q;
  assign o_duty_applied = da_q;
  assign o_cmp_active   = cmp_q;
endmodule

// File: tb/tb_dcdc_pwm_gen.sv
// Directed bench for dcdc_pwm_gen at default parameters; fault cases build with DCDC_PWM_FAULT_EN.
module tb_dcdc_pwm_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [31:0] dc;
  logic        hi, lo, ps, da;
  logic [16:0] cmp;
`ifdef DCDC_PWM_FAULT_EN
  logic        flt, flt_clr, flt_lat;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  dcdc_pwm_gen dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_DC_control    (dc),
    .i_DV            (dv),
`ifdef DCDC_PWM_FAULT_EN
    .i_fault         (flt),
    .i_fault_clr     (flt_clr),
    .o_fault_latched (flt_lat),
`endif
    .o_pwm_hi        (hi),
    .o_pwm_lo        (lo),
    .o_period_start  (ps),
    .o_duty_applied  (da),
    .o_cmp_active    (cmp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ps(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps !== 1'b1 && n < 1100);
    chk({tag, "_ps"}, 32'(ps), 32'd1);
  endtask

  task automatic send(input int k, input logic [31:0] v);
    repeat (k) @(negedge clk);
    dv = 1'b1;
    dc = v;
    @(negedge clk);
    dv = 1'b0;
  endtask

  // Samples one full period starting at the current (period-start) sample.
  task automatic measure(output int hi_n, output int lo_n, output int both_n,
                         output int hi_first, output int lo_rise, output int dp_n);
    logic prev_lo = 1'b0;
    hi_n = 0; lo_n = 0; both_n = 0; hi_first = -1; lo_rise = -1; dp_n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) @(negedge clk);
      if (hi === 1'b1) hi_n++;
      if (lo === 1'b1) lo_n++;
      if (hi === 1'b1 && lo === 1'b1) both_n++;
      if (da === 1'b1) dp_n++;
      if (hi === 1'b1 && hi_first < 0) hi_first = i;
      if (i > 0 && lo === 1'b1 && prev_lo !== 1'b1 && lo_rise < 0) lo_rise = i;
      prev_lo = lo;
    end
  endtask

  initial begin
    int h, l, b, hf, lr, dp;
    rst = 1'b1; dv = 1'b0; dc = '0;
`ifdef DCDC_PWM_FAULT_EN
    flt = 1'b0; flt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_hi", 32'(hi), 0);
    chk("rst_lo", 32'(lo), 0);
    chk("rst_ps", 32'(ps), 0);
    chk("rst_da", 32'(da), 0);
    chk("rst_cmp", 32'(cmp), 500);
`ifdef DCDC_PWM_FAULT_EN
    chk("rst_flt", 32'(flt_lat), 0);
`endif
    rst = 1'b0;

    // Default 50% duty
    wait_ps("p500");
    measure(h, l, b, hf, lr, dp);
    chk("p500_hi", h, 490);
    chk("p500_lo", l, 490);
    chk("p500_both", b, 0);
    chk("p500_hi_first", hf, 11);
    chk("p500_lo_rise", lr, 511);

    // 0x4000 mid-period -> 250 at next wrap
    wait_ps("q25");
    send(300, 32'h0000_4000);
    repeat (2) @(negedge clk);
    chk("q25_hold_cmp", 32'(cmp), 500);
    chk("q25_hold_da", 32'(da), 0);
    wait_ps("q25_apply");
    chk("q25_da", 32'(da), 1);
    chk("q25_cmp", 32'(cmp), 250);
    measure(h, l, b, hf, lr, dp);
    chk("q25_hi", h, 240);
    chk("q25_lo", l, 740);
    chk("q25_dp", dp, 1);
    chk("q25_both", b, 0);

    // Negative request landing on the wrap edge waits a full extra period
    wait_ps("neg");
    send(998, 32'hFFFF_0000);
    wait_ps("neg_late");
    chk("neg_late_da", 32'(da), 0);
    chk("neg_late_cmp", 32'(cmp), 250);
    wait_ps("neg_apply");
    chk("neg_da", 32'(da), 1);
    chk("neg_cmp", 32'(cmp), 0);
    measure(h, l, b, hf, lr, dp);
    chk("neg_hi", h, 0);
    chk("neg_lo", l, 1000);

    // Over-range clamps to full period
    wait_ps("full");
    send(300, 32'h0002_0000);
    wait_ps("full_apply");
    chk("full_cmp", 32'(cmp), 1000);
    wait_ps("full_next");
    measure(h, l, b, hf, lr, dp);
    chk("full_hi", h, 1000);
    chk("full_lo", l, 0);

    // Async reset mid-operation discards a pending request
    wait_ps("rst_mid");
    send(100, 32'h0000_4000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_hi", 32'(hi), 0);
    chk("rstmid_lo", 32'(lo), 0);
    chk("rstmid_cmp", 32'(cmp), 500);
    @(negedge clk);
    rst = 1'b0;
    wait_ps("discard");
    chk("discard_da", 32'(da), 0);
    chk("discard_cmp", 32'(cmp), 500);

    // Two requests in one period: last wins
    send(100, 32'h0000_4000);
    send(298, 32'h0000_C000);
    wait_ps("two");
    chk("two_da", 32'(da), 1);
    chk("two_cmp", 32'(cmp), 750);
    measure(h, l, b, hf, lr, dp);
    chk("two_dp", dp, 1);
    chk("two_hi", h, 740);
    chk("two_lo", l, 240);

    // Tiny duty truncates to 0
    wait_ps("tiny");
    send(300, 32'h0000_0007);
    wait_ps("tiny_apply");
    chk("tiny_cmp", 32'(cmp), 0);
    measure(h, l, b, hf, lr, dp);
    chk("tiny_hi", h, 0);
    chk("tiny_lo", l, 1000);

    // Compare equal to DEADTIME: hi pulse swallowed
    wait_ps("sw");
    send(300, 32'h0000_0290);
    wait_ps("sw_apply");
    chk("sw_cmp", 32'(cmp), 10);
    measure(h, l, b, hf, lr, dp);
    chk("sw_hi", h, 0);
    chk("sw_lo", l, 980);
    chk("sw_lo_rise", lr, 21);

`ifdef DCDC_PWM_FAULT_EN
    wait_ps("flt");
    send(300, 32'h0000_8000);
    wait_ps("flt_apply");
    repeat (100) @(negedge clk);
    chk("flt_pre_hi", 32'(hi), 1);
    flt = 1'b1;
    @(negedge clk);
    flt = 1'b0;
    chk("flt_hi", 32'(hi), 0);
    chk("flt_lo", 32'(lo), 0);
    chk("flt_lat", 32'(flt_lat), 1);
    repeat (20) @(negedge clk);
    chk("flt_hold_hi", 32'(hi), 0);
    chk("flt_hold_lo", 32'(lo), 0);
    flt_clr = 1'b1;
    @(negedge clk);
    flt_clr = 1'b0;
    chk("flt_clr_lat", 32'(flt_lat), 0);
    repeat (10) @(negedge clk);
    chk("flt_dt_hi", 32'(hi), 0);
    @(negedge clk);
    chk("flt_resume_hi", 32'(hi), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
